// File: rtl/scratchpad_fill_dma_if.sv
// rtl/scratchpad_fill_dma_if.sv - control slave, read-master and scratchpad write-port bundle
interface scratchpad_fill_dma_if #(
  parameter int SP_AW = 12
);
  logic [1:0]       ctl_address;
  logic             ctl_chipselect;
  logic             ctl_write;
  logic [31:0]      ctl_writedata;
  logic [31:0]      ctl_readdata;
  logic             irq;
  logic [31:0]      m_address;
  logic             m_read;
  logic             m_waitrequest;
  logic [31:0]      m_readdata;
  logic             m_readdatavalid;
  logic [SP_AW-1:0] sp_address;
  logic             sp_chipselect;
  logic             sp_write;
  logic [3:0]       sp_byteenable;
  logic [31:0]      sp_writedata;
  logic             sp_stall;

  modport master (
    input  ctl_address, ctl_chipselect, ctl_write, ctl_writedata,
    output ctl_readdata, irq,
    output m_address, m_read,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    output sp_address, sp_chipselect, sp_write, sp_byteenable, sp_writedata,
    input  sp_stall
  );

  modport slave (
    output ctl_address, ctl_chipselect, ctl_write, ctl_writedata,
    input  ctl_readdata, irq,
    input  m_address, m_read,
    output m_waitrequest, m_readdata, m_readdatavalid,
    input  sp_address, sp_chipselect, sp_write, sp_byteenable, sp_writedata,
    output sp_stall
  );
endinterface

// File: rtl/scratchpad_fill_dma.sv
// rtl/scratchpad_fill_dma.sv - system-memory to scratchpad block-fill DMA engine
module scratchpad_fill_dma #(
  parameter int FIFO_DEPTH = 4,
  parameter int SP_AW      = 12,
  parameter int LEN_W      = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  scratchpad_fill_dma_if.master io_bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]      r_src;
  logic [SP_AW-1:0] r_dst;
  logic [LEN_W-1:0] r_len;
  logic             r_irq_en, r_done;
  logic [31:0]      r_m_addr;
  logic             r_req_pending;
  logic [LEN_W-1:0] r_issued, r_written;
  logic [CW-1:0]    r_outstanding, r_fifo_cnt;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [31:0]      r_fifo_mem [FIFO_DEPTH];
  logic [SP_AW-1:0] r_sp_addr;
  logic             r_sp_write;
  logic [31:0]      r_sp_data;

  logic        w_ctl_wr, w_wr_ctrl, w_start, w_abort, w_done_clr, w_complete;
  logic        w_launch, w_zero_start, w_accept, w_ret;
  logic [CW:0] w_inflight;
  logic        w_busy, w_m_read, w_push, w_pop;
  logic [31:0] w_rdata;

  assign w_ctl_wr     = io_bus.ctl_chipselect & io_bus.ctl_write;
  assign w_wr_ctrl    = w_ctl_wr && (io_bus.ctl_address == 2'd0);
  assign w_start      = w_wr_ctrl & io_bus.ctl_writedata[0];
  assign w_abort      = w_wr_ctrl & io_bus.ctl_writedata[1];
  assign w_done_clr   = w_wr_ctrl & io_bus.ctl_writedata[2];
  assign w_launch     = (r_state == S_IDLE) && w_start && (r_len != '0);
  assign w_zero_start = (r_state == S_IDLE) && w_start && (r_len == '0);
  assign w_complete   = (r_state == S_RUN) && (r_written == r_len);
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_accept     = w_m_read & ~io_bus.m_waitrequest;
  // Returns with nothing outstanding (stale, after reset) are dropped.
  assign w_ret        = io_bus.m_readdatavalid && (r_outstanding != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: completion outranks a same-cycle abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (w_complete) w_state_nxt = S_IDLE;
               else if (w_abort) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_outstanding == '0) && !r_req_pending) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state strobes; a read stalled at abort time stays asserted until accepted.
  always_comb begin
    w_busy   = 1'b0;
    w_m_read = 1'b0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_busy   = 1'b1;
        w_m_read = (r_issued < r_len) && (w_inflight < DEPTH_V);
        w_push   = w_ret;
        w_pop    = (r_fifo_cnt != '0) && !io_bus.sp_stall;
      end
      S_DRAIN: begin
        w_busy   = 1'b1;
        w_m_read = r_req_pending;
      end
      default: ;
    endcase
  end

  // Register file: setup registers are frozen while busy; completion beats a W1C of done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_ctl_wr && !w_busy && (io_bus.ctl_address == 2'd1)) r_src <= {io_bus.ctl_writedata[31:2], 2'b00};
      if (w_ctl_wr && !w_busy && (io_bus.ctl_address == 2'd2)) r_dst <= io_bus.ctl_writedata[SP_AW-1:0];
      if (w_ctl_wr && !w_busy && (io_bus.ctl_address == 2'd3)) r_len <= io_bus.ctl_writedata[LEN_W-1:0];
      if (w_wr_ctrl) r_irq_en <= io_bus.ctl_writedata[3];
      if (w_complete || w_zero_start) r_done <= 1'b1;
      else if (w_done_clr)            r_done <= 1'b0;
    end
  end

  // Read issue, outstanding tracking, FIFO pointers and the registered scratchpad write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m_addr      <= '0;
      r_req_pending <= 1'b0;
      r_issued      <= '0;
      r_written     <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_sp_addr     <= '0;
      r_sp_write    <= 1'b0;
      r_sp_data     <= '0;
    end else begin
      r_req_pending <= w_m_read & io_bus.m_waitrequest;
      if (w_launch) begin
        r_m_addr  <= r_src;
        r_issued  <= '0;
        r_written <= '0;
      end
      if (w_accept && (r_state == S_RUN)) begin
        r_m_addr <= r_m_addr + 32'd4;
        r_issued <= r_issued + 1'b1;
      end
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_ret);
      if (r_state != S_RUN) begin
        r_fifo_cnt <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
      end
      if (!io_bus.sp_stall) begin
        r_sp_write <= w_pop;
        if (w_pop) begin
          r_sp_addr <= r_dst + r_written[SP_AW-1:0];
          r_sp_data <= r_fifo_mem[r_rd_ptr];
          r_written <= r_written + 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= io_bus.m_readdata;
  end

  // Zero-latency register readback.
  always_comb begin
    w_rdata = '0;
    case (io_bus.ctl_address)
      2'd0:    w_rdata = {28'd0, r_irq_en, r_done, 1'b0, w_busy};
      2'd1:    w_rdata = r_src;
      2'd2:    w_rdata = {{(32-SP_AW){1'b0}}, r_dst};
      default: w_rdata = {{(32-LEN_W){1'b0}}, r_len};
    endcase
  end

  assign io_bus.ctl_readdata  = w_rdata;
  assign io_bus.irq           = r_done & r_irq_en;
  assign io_bus.m_address     = r_m_addr;
  assign io_bus.m_read        = w_m_read;
  assign io_bus.sp_address    = r_sp_addr;
  assign io_bus.sp_chipselect = r_sp_write;
  assign io_bus.sp_write      = r_sp_write;
  assign io_bus.sp_byteenable = r_sp_write ? 4'hF : 4'h0;
  assign io_bus.sp_writedata  = r_sp_data;
endmodule

// File: tb/tb_scratchpad_fill_dma.sv
// tb/tb_scratchpad_fill_dma.sv - randomized self-checking bench for scratchpad_fill_dma
module tb_scratchpad_fill_dma;
  localparam int FIFO_DEPTH = 4;
  localparam int SP_AW      = 12;
  localparam int LEN_W      = 13;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  scratchpad_fill_dma_if #(.SP_AW(SP_AW)) bus_if ();

  scratchpad_fill_dma #(.FIFO_DEPTH(FIFO_DEPTH), .SP_AW(SP_AW), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus_if.master)
  );

  typedef struct { logic [31:0] addr; int due; } rd_t;
  typedef struct { logic [SP_AW-1:0] a; logic [31:0] d; } wr_t;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  rd_t rsp_q[$];
  logic [31:0] exp_rd_q[$];
  wr_t exp_wr_q[$];
  int n_rd_acc = 0, n_wr_acc = 0, n_mread_cyc = 0;
  int lat = 1, wmode = 0, smode = 0, hold_until = 0;
  bit chk_inflight = 0, no_writes = 0;
  int base_r = 0, base_w = 0;
  bit prev_stall = 0;
  logic [31:0] prev_addr = '0;
  rd_t rsp_head;
  wr_t wr_head;

  // memory contents seen by the read master
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory responder and stall drivers, updated just after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    bus_if.m_waitrequest = (wmode == 1) ? ($urandom_range(0, 9) < 3) : ((wmode == 2) && (cyc < hold_until));
    bus_if.sp_stall = (smode == 1) ? cyc[0] : ((smode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rsp_head = rsp_q.pop_front();
      bus_if.m_readdatavalid = 1'b1;
      bus_if.m_readdata = mem_word(rsp_head.addr);
    end else begin
      bus_if.m_readdatavalid = 1'b0;
      bus_if.m_readdata = $urandom;
    end
  end

  // bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_inflight)
      check_eq("inflight_le_depth",
               ((n_rd_acc - base_r) - (n_wr_acc - base_w) - int'(bus_if.sp_write)) <= FIFO_DEPTH, 1);
    if (!reset_n) prev_stall = 1'b0;
    else if (prev_stall) begin
      check_eq("m_read_held", bus_if.m_read, 1);
      check_eq("m_addr_held", bus_if.m_address, prev_addr);
    end
    prev_stall = bus_if.m_read & bus_if.m_waitrequest;
    prev_addr  = bus_if.m_address;
    if (bus_if.m_read) n_mread_cyc++;
    if (bus_if.m_read && !bus_if.m_waitrequest) begin
      n_rd_acc++;
      rsp_q.push_back('{bus_if.m_address, cyc + lat});
      check_eq("rd_expected", exp_rd_q.size() > 0, 1);
      if (exp_rd_q.size() > 0) check_eq("rd_addr", bus_if.m_address, exp_rd_q.pop_front());
    end
    if (bus_if.sp_write) begin
      check_eq("sp_chipselect", bus_if.sp_chipselect, 1);
      check_eq("sp_byteenable", bus_if.sp_byteenable, 4'hF);
    end
    if (bus_if.sp_write && !bus_if.sp_stall) begin
      n_wr_acc++;
      check_eq("wr_expected", (exp_wr_q.size() > 0) && !no_writes, 1);
      if (exp_wr_q.size() > 0) begin
        wr_head = exp_wr_q.pop_front();
        check_eq("sp_address", bus_if.sp_address, wr_head.a);
        check_eq("sp_writedata", bus_if.sp_writedata, wr_head.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.ctl_address = a;
    bus_if.ctl_writedata = d;
    bus_if.ctl_chipselect = 1'b1;
    bus_if.ctl_write = 1'b1;
    tick();
    bus_if.ctl_chipselect = 1'b0;
    bus_if.ctl_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    bus_if.ctl_address = a;
    bus_if.ctl_chipselect = 1'b1;
    @(negedge clk);
    d = bus_if.ctl_readdata;
    tick();
    bus_if.ctl_chipselect = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    int k = 0;
    reg_rd(2'd0, st);
    while (st[0] && k < budget) begin
      reg_rd(2'd0, st);
      k++;
    end
    check_eq("busy_clears", st[0], 0);
  endtask

  task automatic expect_xfer(input logic [31:0] src, input logic [SP_AW-1:0] dst, input int len);
    logic [31:0] s;
    s = src & ~32'h3;
    for (int i = 0; i < len; i++) begin
      exp_rd_q.push_back(s + 32'(4 * i));
      exp_wr_q.push_back('{SP_AW'(dst + SP_AW'(i)), mem_word(s + 32'(4 * i))});
    end
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [SP_AW-1:0] dst, input int len,
                          input int l, input int wm, input int sm, input bit ien);
    logic [31:0] st;
    int wbase;
    lat = l; wmode = wm; smode = sm;
    reg_wr(2'd0, {28'd0, ien, 1'b1, 2'b00});
    reg_wr(2'd1, src);
    reg_wr(2'd2, 32'(dst));
    reg_wr(2'd3, 32'(len));
    expect_xfer(src, dst, len);
    base_r = n_rd_acc; base_w = n_wr_acc; wbase = n_wr_acc;
    chk_inflight = 1;
    hold_until = cyc + 6;
    reg_wr(2'd0, {28'd0, ien, 3'b001});
    wait_idle(3000);
    repeat (4) tick();
    chk_inflight = 0;
    check_eq("words_written", n_wr_acc - wbase, len);
    check_eq("exp_wr_left", exp_wr_q.size(), 0);
    check_eq("exp_rd_left", exp_rd_q.size(), 0);
    reg_rd(2'd0, st);
    check_eq("done_set", st[2], 1);
    check_eq("irq_level", bus_if.irq, ien);
    exp_rd_q.delete();
    exp_wr_q.delete();
    wmode = 0; smode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int k, wbase, rbase;
    bus_if.ctl_address = '0;
    bus_if.ctl_chipselect = 1'b0;
    bus_if.ctl_write = 1'b0;
    bus_if.ctl_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset state
    @(negedge clk);
    check_eq("rst_m_read", bus_if.m_read, 0);
    check_eq("rst_m_address", bus_if.m_address, 0);
    check_eq("rst_sp_write", bus_if.sp_write, 0);
    check_eq("rst_irq", bus_if.irq, 0);
    check_eq("rst_ctrl", bus_if.ctl_readdata, 0);
    tick();
    reg_wr(2'd1, 32'h0000_1003);
    reg_rd(2'd1, rd);
    check_eq("src_align", rd, 32'h0000_1000);

    // basic fill, latency 2
    run_xfer(32'h0000_1000, 12'h010, 8, 2, 0, 0, 1'b1);

    // zero length
    reg_wr(2'd0, 32'h4);
    reg_wr(2'd3, 32'h0);
    wbase = n_wr_acc; rbase = n_mread_cyc;
    reg_wr(2'd0, 32'h1);
    reg_rd(2'd0, rd);
    check_eq("len0_done", rd[2], 1);
    check_eq("len0_busy", rd[0], 0);
    repeat (5) tick();
    check_eq("len0_no_read", n_mread_cyc - rbase, 0);
    check_eq("len0_no_write", n_wr_acc - wbase, 0);

    // scratchpad address wrap, read address wrap
    run_xfer(32'h0000_4000, 12'hFFE, 4, 1, 0, 0, 1'b0);
    run_xfer(32'hFFFF_FFF8, 12'h300, 4, 1, 0, 0, 1'b0);

    // waitrequest held 5 cycles, scratchpad stall toggling
    run_xfer(32'h0000_5000, 12'h200, 16, 3, 2, 1, 1'b1);

    // randomized transfers
    for (int t = 0; t < 8; t++)
      run_xfer($urandom & ~32'h3, SP_AW'($urandom), $urandom_range(1, 24), $urandom_range(1, 4),
               $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));

    // abort mid-transfer
    lat = 6; wmode = 0; smode = 0;
    reg_wr(2'd0, 32'h4);
    reg_wr(2'd1, 32'h0000_2000);
    reg_wr(2'd2, 32'h40);
    reg_wr(2'd3, 32'd10);
    expect_xfer(32'h0000_2000, 12'h040, 10);
    wbase = n_wr_acc;
    reg_wr(2'd0, 32'h1);
    reg_wr(2'd1, 32'hDEAD_0000);
    reg_rd(2'd1, rd);
    check_eq("src_locked_busy", rd, 32'h0000_2000);
    k = 0;
    while ((n_wr_acc - wbase) < 3 && k < 300) begin tick(); k++; end
    check_eq("abort_3_written", (n_wr_acc - wbase) >= 3, 1);
    check_eq("abort_outstanding", rsp_q.size() >= 2, 1);
    reg_wr(2'd0, 32'h2);
    tick();
    no_writes = 1;
    exp_rd_q.delete();
    reg_rd(2'd0, rd);
    k = 0;
    while (rd[0] && k < 300) begin reg_rd(2'd0, rd); k++; end
    check_eq("abort_busy_clears", rd[0], 0);
    check_eq("busy_after_last_return", (rsp_q.size() == 0) && !bus_if.m_readdatavalid, 1);
    check_eq("abort_done_clear", rd[2], 0);
    repeat (10) tick();
    no_writes = 0;
    exp_wr_q.delete();

    // reset mid-transfer
    lat = 4;
    reg_wr(2'd0, 32'h8 | 32'h4);
    reg_wr(2'd1, 32'h0000_3000);
    reg_wr(2'd2, 32'h100);
    reg_wr(2'd3, 32'd10);
    expect_xfer(32'h0000_3000, 12'h100, 10);
    wbase = n_wr_acc;
    reg_wr(2'd0, 32'h8 | 32'h1);
    k = 0;
    while ((n_wr_acc - wbase) < 3 && k < 300) begin tick(); k++; end
    bus_if.ctl_address = 2'd0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_rd_q.delete();
    exp_wr_q.delete();
    wbase = n_wr_acc;
    @(negedge clk);
    check_eq("mid_rst_m_read", bus_if.m_read, 0);
    check_eq("mid_rst_m_address", bus_if.m_address, 0);
    check_eq("mid_rst_sp_write", bus_if.sp_write, 0);
    check_eq("mid_rst_sp_cs", bus_if.sp_chipselect, 0);
    check_eq("mid_rst_sp_addr", bus_if.sp_address, 0);
    check_eq("mid_rst_sp_data", bus_if.sp_writedata, 0);
    check_eq("mid_rst_sp_be", bus_if.sp_byteenable, 0);
    check_eq("mid_rst_irq", bus_if.irq, 0);
    check_eq("mid_rst_ctrl", bus_if.ctl_readdata, 0);
    tick();
    reg_rd(2'd1, rd); check_eq("mid_rst_src", rd, 0);
    reg_rd(2'd2, rd); check_eq("mid_rst_dst", rd, 0);
    reg_rd(2'd3, rd); check_eq("mid_rst_len", rd, 0);
    repeat (12) tick();
    check_eq("late_returns_drained", rsp_q.size(), 0);
    check_eq("late_no_write", n_wr_acc - wbase, 0);

    // engine usable after reset
    run_xfer(32'h0000_6000, 12'h7F0, 6, 2, 1, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
